// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: requester-side and shared-bus signals of the memory arbiter
interface mem_bus_arbiter_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_done;
  logic        inst_stall;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_done;
  logic        data_stall;
  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;
  modport master (
    input  inst_req, inst_addr, data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
           bus_addr_ok, bus_data_ok, bus_rdata,
    output inst_rdata, inst_done, inst_stall, data_rdata, data_done, data_stall,
           bus_req, bus_wr, bus_size, bus_addr, bus_wstrb, bus_wdata
  );
  modport slave (
    output inst_req, inst_addr, data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
           bus_addr_ok, bus_data_ok, bus_rdata,
    input  inst_rdata, inst_done, inst_stall, data_rdata, data_done, data_stall,
           bus_req, bus_wr, bus_size, bus_addr, bus_wstrb, bus_wdata
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: single-outstanding arbiter of fetch and data requesters onto one req/addr_ok/data_ok bus
module mem_bus_arbiter #(
  parameter logic PRIO_DATA = 1'b1
) (
  input logic             clk,
  input logic             resetn,
  mem_bus_arbiter_if.master mb
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;
  state_t state;
  logic   last_data;
  logic   gnt_data;
  logic   pick_data;
  // a tie goes to data under fixed priority, otherwise to the side not granted last
  assign pick_data = mb.data_req & (~mb.inst_req | PRIO_DATA | ~last_data);
  assign mb.inst_stall = mb.inst_req & ~mb.inst_done;
  assign mb.data_stall = mb.data_req & ~mb.data_done;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state         <= IDLE;
      last_data     <= 1'b0;
      gnt_data      <= 1'b0;
      mb.bus_req    <= 1'b0;
      mb.bus_wr     <= 1'b0;
      mb.bus_size   <= 2'b00;
      mb.bus_addr   <= 32'h0;
      mb.bus_wstrb  <= 4'h0;
      mb.bus_wdata  <= 32'h0;
      mb.inst_rdata <= 32'h0;
      mb.data_rdata <= 32'h0;
      mb.inst_done  <= 1'b0;
      mb.data_done  <= 1'b0;
    end else begin
      mb.inst_done <= 1'b0;
      mb.data_done <= 1'b0;
      case (state)
        IDLE: if (mb.inst_req | mb.data_req) begin
          state        <= ADDR;
          gnt_data     <= pick_data;
          last_data    <= pick_data;
          mb.bus_req   <= 1'b1;
          mb.bus_wr    <= pick_data & mb.data_wr;
          mb.bus_size  <= pick_data ? mb.data_size : 2'b10;
          mb.bus_addr  <= pick_data ? mb.data_addr : mb.inst_addr;
          mb.bus_wstrb <= (pick_data & mb.data_wr) ? mb.data_wstrb : 4'h0;
          mb.bus_wdata <= pick_data ? mb.data_wdata : 32'h0;
        end
        ADDR: if (mb.bus_addr_ok) begin
          state      <= DATA;
          mb.bus_req <= 1'b0;
        end
        DATA: if (mb.bus_data_ok) begin
          state <= RESP;
          if (gnt_data) begin
            mb.data_rdata <= mb.bus_rdata;
            mb.data_done  <= 1'b1;
          end else begin
            mb.inst_rdata <= mb.bus_rdata;
            mb.inst_done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: scoreboard bench; a fixed-priority DUT faces a bus model, a round-robin twin shadows its inputs
module tb_mem_bus_arbiter;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;
  mem_bus_arbiter_if m();
  mem_bus_arbiter_if r();
  mem_bus_arbiter #(.PRIO_DATA(1'b1)) u_pd (.clk(clk), .resetn(resetn), .mb(m));
  mem_bus_arbiter #(.PRIO_DATA(1'b0)) u_rr (.clk(clk), .resetn(resetn), .mb(r));
  assign r.inst_req    = m.inst_req;
  assign r.inst_addr   = m.inst_addr;
  assign r.data_req    = m.data_req;
  assign r.data_wr     = m.data_wr;
  assign r.data_size   = m.data_size;
  assign r.data_addr   = m.data_addr;
  assign r.data_wstrb  = m.data_wstrb;
  assign r.data_wdata  = m.data_wdata;
  assign r.bus_addr_ok = m.bus_addr_ok;
  assign r.bus_data_ok = m.bus_data_ok;
  assign r.bus_rdata   = m.bus_rdata;
  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;
  txn_t        exp_bus[$];
  txn_t        exp_inst[$];
  txn_t        exp_data[$];
  logic [31:0] exp_rr[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   addr_wait = 0;
  int   data_wait = 0;
  logic spur = 1'b0;
  logic hold = 1'b0;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // bus responder: checks latched fields every request cycle, answers with the scoreboard's rdata
  int   phase = 0;
  int   acnt = 0;
  int   dcnt = 0;
  txn_t cur;
  always @(posedge clk or negedge resetn)
    if (!resetn) begin
      phase = 0;
      acnt = 0;
      m.bus_addr_ok = 1'b0;
      m.bus_data_ok = 1'b0;
      m.bus_rdata = 32'h0;
    end else begin
      #2;
      m.bus_addr_ok = 1'b0;
      m.bus_data_ok = 1'b0;
      if (!resetn) begin
        phase = 0;
        acnt = 0;
      end else if (phase == 0 && m.bus_req) begin
        if (exp_bus.size() == 0) check("bus_unexpected_req", m.bus_req, 0);
        else begin
          cur = exp_bus[0];
          check("bus_wr", m.bus_wr, cur.wr);
          check("bus_size", m.bus_size, cur.size);
          check("bus_addr", m.bus_addr, cur.addr);
          check("bus_wstrb", m.bus_wstrb, cur.wstrb);
          check("bus_wdata", m.bus_wdata, cur.wdata);
          if (spur) begin
            m.bus_data_ok = 1'b1;
            spur = 1'b0;
          end
          if (acnt == addr_wait) begin
            m.bus_addr_ok = 1'b1;
            void'(exp_bus.pop_front());
            phase = 1;
            dcnt = 0;
            acnt = 0;
          end else acnt++;
        end
      end else if (phase == 1) begin
        if (dcnt == data_wait) begin
          m.bus_data_ok = 1'b1;
          m.bus_rdata = cur.rdata;
          phase = 0;
        end else dcnt++;
      end
    end
  txn_t got_t;
  always @(negedge clk) begin
    if (m.inst_done) begin
      if (exp_inst.size() == 0) check("inst_done_unexpected", m.inst_done, 0);
      else begin
        got_t = exp_inst.pop_front();
        check("inst_rdata", m.inst_rdata, got_t.rdata);
      end
    end
    if (m.data_done) begin
      if (exp_data.size() == 0) check("data_done_unexpected", m.data_done, 0);
      else begin
        got_t = exp_data.pop_front();
        if (!got_t.wr) check("data_rdata", m.data_rdata, got_t.rdata);
      end
    end
    if (r.bus_req && r.bus_addr_ok && exp_rr.size() != 0) check("rr_order", r.bus_addr, exp_rr.pop_front());
  end
  task automatic nc();
    logic id, dd;
    id = m.inst_done;
    dd = m.data_done;
    @(posedge clk);
    #2;
    if (!hold) begin
      if (id) m.inst_req = 1'b0;
      if (dd) m.data_req = 1'b0;
    end
  endtask
  task automatic req_inst(logic [31:0] a, logic [31:0] rd);
    txn_t t;
    t = '{1'b0, 2'b10, a, 4'h0, 32'h0, rd};
    m.inst_req = 1'b1;
    m.inst_addr = a;
    exp_bus.push_back(t);
    exp_inst.push_back(t);
  endtask
  task automatic req_data(logic wr, logic [1:0] sz, logic [31:0] a, logic [3:0] st, logic [31:0] wd, logic [31:0] rd);
    txn_t t;
    t = '{wr, sz, a, wr ? st : 4'h0, wd, rd};
    m.data_req = 1'b1;
    m.data_wr = wr;
    m.data_size = sz;
    m.data_addr = a;
    m.data_wstrb = st;
    m.data_wdata = wd;
    exp_bus.push_back(t);
    exp_data.push_back(t);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end
  initial begin
    m.inst_req = 1'b0;
    m.inst_addr = 32'h0;
    m.data_req = 1'b0;
    m.data_wr = 1'b0;
    m.data_size = 2'b00;
    m.data_addr = 32'h0;
    m.data_wstrb = 4'h0;
    m.data_wdata = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_bus_req", m.bus_req, 0);
    check("rst_bus_addr", m.bus_addr, 0);
    check("rst_inst_rdata", m.inst_rdata, 0);
    check("rst_data_rdata", m.data_rdata, 0);
    check("rst_done", {m.inst_done, m.data_done}, 0);
    check("rst_stall", {m.inst_stall, m.data_stall}, 0);
    nc();
    resetn = 1'b1;
    nc();
    nc();
    // single load, zero-wait bus
    req_data(1'b0, 2'b10, 32'h10, 4'hF, 32'h12345678, 32'hDEADBEEF);
    @(negedge clk);
    check("load_stall_c0", m.data_stall, 1);
    for (int c = 1; c <= 5; c++) begin
      nc();
      @(negedge clk);
      check("load_bus_req", m.bus_req, c == 1);
      check("load_done", m.data_done, c == 3);
      check("load_stall", m.data_stall, c < 3);
      if (c >= 3) check("load_rdata_held", m.data_rdata, 32'hDEADBEEF);
    end
    // byte store, address phase stretched by three wait cycles, inputs disturbed mid-flight
    addr_wait = 3;
    req_data(1'b1, 2'b00, 32'h13, 4'b1000, 32'hABABABAB, 32'h0);
    for (int c = 1; c <= 8; c++) begin
      nc();
      if (c == 2) begin
        m.data_addr = 32'hFFFFFFFC;
        m.data_wdata = 32'h0;
        m.data_wstrb = 4'hF;
      end
      @(negedge clk);
      check("store_bus_req", m.bus_req, c >= 1 && c <= 4);
      check("store_done", m.data_done, c == 6);
      if (c <= 6) check("store_addr_stable", m.bus_addr, 32'h13);
    end
    addr_wait = 0;
    nc();
    // simultaneous requests under fixed data priority
    req_data(1'b0, 2'b10, 32'h20, 4'h0, 32'h0, 32'h11112222);
    req_inst(32'h100, 32'h33334444);
    for (int c = 1; c <= 9; c++) begin
      nc();
      @(negedge clk);
      check("tie_inst_stall", m.inst_stall, c < 7);
      check("tie_bus_req", m.bus_req, c == 1 || c == 5);
      check("tie_data_done", m.data_done, c == 3);
      check("tie_inst_done", m.inst_done, c == 7);
    end
    // spurious data_ok while the address phase is still pending
    addr_wait = 2;
    spur = 1'b1;
    req_inst(32'h44, 32'hCAFEF00D);
    for (int c = 1; c <= 7; c++) begin
      nc();
      @(negedge clk);
      check("spur_bus_req", m.bus_req, c >= 1 && c <= 3);
      check("spur_inst_done", m.inst_done, c == 5);
    end
    addr_wait = 0;
    // reset while waiting in the data phase
    data_wait = 3;
    req_inst(32'h80, 32'h55556666);
    nc();
    nc();
    @(negedge clk);
    check("mid_in_data", m.bus_req, 0);
    nc();
    resetn = 1'b0;
    m.inst_req = 1'b0;
    exp_inst.delete();
    #1;
    check("mid_rst_bus_addr", m.bus_addr, 0);
    check("mid_rst_inst_rdata", m.inst_rdata, 0);
    check("mid_rst_data_rdata", m.data_rdata, 0);
    check("mid_rst_flags", {m.bus_req, m.inst_done, m.data_done, m.inst_stall, m.data_stall}, 0);
    nc();
    resetn = 1'b1;
    data_wait = 0;
    nc();
    nc();
    req_inst(32'h84, 32'h77778888);
    for (int c = 1; c <= 5; c++) begin
      nc();
      @(negedge clk);
      check("post_rst_bus_req", m.bus_req, c == 1);
      check("post_rst_done", m.inst_done, c == 3);
      check("post_rst_stall", m.inst_stall, c < 3);
    end
    // both requests held for four grants: fixed priority serves data only, round-robin alternates
    hold = 1'b1;
    for (int i = 0; i < 4; i++) req_data(1'b0, 2'b10, 32'h30, 4'h0, 32'h0, 32'h90000000 + i);
    m.inst_req = 1'b1;
    m.inst_addr = 32'h200;
    exp_rr.push_back(32'h30);
    exp_rr.push_back(32'h200);
    exp_rr.push_back(32'h30);
    exp_rr.push_back(32'h200);
    for (int c = 1; c <= 16; c++) begin
      nc();
      if (c == 16) begin
        m.data_req = 1'b0;
        m.inst_req = 1'b0;
        hold = 1'b0;
      end
      @(negedge clk);
      check("rr_inst_stall", m.inst_stall, c < 16);
    end
    repeat (3) nc();
    @(negedge clk);
    check("left_bus", exp_bus.size(), 0);
    check("left_inst", exp_inst.size(), 0);
    check("left_data", exp_data.size(), 0);
    check("left_rr", exp_rr.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Single-outstanding arbiter and sequencer between the CPU's two memory requesters (instruction fetch and the M-stage data access) and one shared SRAM-like bus (req/addr_ok/data_ok). It sits behind the memory byte-select logic. Data requests arrive with size, byte strobes and replicated write data already formed, and with misaligned accesses already suppressed. The block grants one requester at a time, runs the two-phase bus handshake, returns read data and completion pulses, and drives stall signals to the pipeline.

## Interface
- PRIO_DATA, 1, 1: data side wins every simultaneous request; 0: round-robin on tie (requester not granted last wins)
- clk  in  1  system clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- inst_req  in  1  fetch request; held until inst_done
- inst_addr  in  32  fetch address (word aligned)
- inst_rdata  out  32  fetched word; valid with inst_done, held until next inst completion
- inst_done  out  1  one-cycle completion pulse
- inst_stall  out  1  inst_req & ~inst_done
- data_req  in  1  data request; held until data_done
- data_wr  in  1  1 = store, 0 = load
- data_size  in  2  00 byte, 01 half, 10 word
- data_addr  in  32  byte address
- data_wstrb  in  4  byte-lane write enables
- data_wdata  in  32  lane-replicated store data
- data_rdata  out  32  raw load word; valid with data_done, held until next data completion
- data_done  out  1  one-cycle completion pulse
- data_stall  out  1  data_req & ~data_done
- bus_req  out  1  bus request, held until addr_ok
- bus_wr  out  1  write flag
- bus_size  out  2  transfer size
- bus_addr  out  32  address
- bus_wstrb  out  4  byte strobes, 0000 for every read
- bus_wdata  out  32  write data
- bus_addr_ok  in  1  address phase accepted
- bus_data_ok  in  1  data phase complete
- bus_rdata  in  32  read data, valid with bus_data_ok

## Operation
- States:
  - IDLE: no grant. Any request moves to ADDR.
  - ADDR: bus_req=1. bus_addr_ok moves to DATA.
  - DATA: waiting for data. bus_data_ok moves to RESP.
  - RESP: done pulse. Always returns to IDLE.
- Grant (IDLE only):
  - Only one requester active: grant it.
  - Both active: PRIO_DATA=1 grants data; PRIO_DATA=0 grants the side opposite last_grant.
  - last_grant resets to inst, so the first tie under PRIO_DATA=0 goes to data.
- On grant, latch bus_wr/size/addr/wstrb/wdata into registers; bus_* outputs come only from these registers.
  - inst grant: wr=0, size=10, wstrb=0000, wdata=0.
  - data grant: data_* fields, with wstrb forced to 0000 when data_wr=0.
  - Latched fields stay stable from ADDR through RESP regardless of input changes.
- DATA + bus_data_ok: capture bus_rdata into the granted side's rdata register. Stores also capture, and the value is don't-care.
- RESP: the granted side's done=1 for exactly one cycle; both req inputs are ignored this cycle.
- bus_data_ok outside DATA and bus_addr_ok outside ADDR are ignored.
- bus_req drops in the cycle after bus_addr_ok is sampled.

## Timing
- Reset (resetn=0, asynchronous): state=IDLE, last_grant=inst, and every output = 0, including both rdata registers.
- Minimum latency, with a request first seen in IDLE at cycle 0 and zero-wait bus responses:
  - bus_req high in cycle 1; bus_addr_ok in cycle 1.
  - State DATA in cycle 2; bus_data_ok in cycle 2.
  - done and rdata in cycle 3.
  - Earliest new grant at cycle 4 (IDLE sampled), which puts bus_req back up in cycle 5.
- Each wait cycle on bus_addr_ok or bus_data_ok adds one cycle.
- The losing requester stays stalled and is granted in the first IDLE cycle after RESP, subject to the grant rule.
- Requester dropping req mid-transaction: the transaction still completes and done still pulses; there is no cancel.
- resetn asserted mid-transaction: the bus transaction is abandoned and bus_req drops immediately. Bus-side recovery is outside this block.

## Test plan
- Single load: data_req, addr=0x10, size=10, bus_addr_ok in cycle 1, bus_data_ok with rdata=0xDEADBEEF in cycle 2 -> bus_wstrb=0000, data_done in cycle 3 only, data_rdata=0xDEADBEEF, data_stall low from cycle 3.
- Byte store: data_wr=1, addr=0x13, wstrb=1000, wdata=0xABABABAB, bus_addr_ok delayed 3 cycles -> bus_req and fields stable for 4 cycles, then drops; data_done 1 cycle after bus_data_ok.
- Tie with PRIO_DATA=1: inst_req and data_req both rise in the same cycle -> data served first; inst bus_req rises in the cycle after data_done's RESP cycle; inst_stall stays high throughout.
- Round-robin with PRIO_DATA=0: both requests held continuously for 4 transactions -> grant order data, inst, data, inst.
- Spurious handshake: bus_data_ok pulsed while in ADDR -> ignored, no done; the later real bus_addr_ok then bus_data_ok complete normally.
- Reset mid-DATA: resetn low for 1 cycle -> all outputs 0 immediately; a subsequent inst_req is served from IDLE with 4-cycle minimum latency.
